// File: rtl/control_sequencer.sv
// Datapath control sequencer: IDLE/INIT/RUN/FINISH FSM with combinational instruction decode in RUN.
// Optional RUN-cycle watchdog enabled by defining CTRL_WATCHDOG_EN (default build: disabled, timeout tied low).
//
// state  | meaning
// IDLE   | waiting for go; all controls low
// INIT   | START high for INIT_CYCLES cycles (datapath reset)
// RUN    | controls decoded from opcode/fcode, cycle_count running
// FINISH | program done, outputs held until ack
module control_sequencer #(
   parameter int unsigned INIT_CYCLES = 2,
   parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        go,
   input  logic        ack,
   input  logic [3:0]  opcode,
   input  logic        fcode,
   input  logic        dp_done,
   output logic        START,
   output logic        CTRL_branch_rel_nz,
   output logic        CTRL_branch_rel_z,
   output logic        CTRL_branch_abs,
   output logic        CTRL_reg_write_en,
   output logic        CTRL_reg_sel,
   output logic        CTRL_lut_in,
   output logic        CTRL_mem_to_reg,
   output logic        CTRL_alu_src,
   output logic        CTRL_alu_sc_in,
   output logic        CTRL_read_mem,
   output logic        CTRL_write_mem,
   output logic [2:0]  CTRL_alu_op,
   output logic        busy,
   output logic        finished,
   output logic        timeout,
   output logic [15:0] cycle_count
);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_FINISH} state_t;

`ifdef CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   state_t      r_state;
   logic [3:0]  r_init_cnt;
   logic [15:0] r_cycle_count;
   logic        r_timeout;
   logic [15:0] w_cnt_next;
   logic        w_wd_hit;
   logic        w_run_exit;

   assign w_cnt_next = (r_cycle_count == 16'hFFFF) ? r_cycle_count : r_cycle_count + 16'd1;
   assign w_wd_hit   = WD_EN && (w_cnt_next >= MAX_CYCLES);
   assign w_run_exit = dp_done || (opcode == 4'hF);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_init_cnt    <= 4'd0;
         r_cycle_count <= 16'd0;
         r_timeout     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_state       <= S_INIT;
                  r_init_cnt    <= 4'(INIT_CYCLES - 1);
                  r_cycle_count <= 16'd0;
                  r_timeout     <= 1'b0;
               end
            end
            S_INIT: begin
               if (r_init_cnt == 4'd0) r_state <= S_RUN;
               else                    r_init_cnt <= r_init_cnt - 4'd1;
            end
            S_RUN: begin
               r_cycle_count <= w_cnt_next;
               if (w_wd_hit) r_timeout <= 1'b1;
               if (w_wd_hit || w_run_exit) r_state <= S_FINISH;
            end
            S_FINISH: begin
               if (ack) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign START       = (r_state == S_INIT);
   assign busy        = (r_state == S_INIT) || (r_state == S_RUN);
   assign finished    = (r_state == S_FINISH);
   assign timeout     = r_timeout;
   assign cycle_count = r_cycle_count;

   // Decode is gated by RUN so no write or branch can leak out in other states.
   always_comb begin
      CTRL_branch_rel_nz = 1'b0;
      CTRL_branch_rel_z  = 1'b0;
      CTRL_branch_abs    = 1'b0;
      CTRL_reg_write_en  = 1'b0;
      CTRL_reg_sel       = 1'b0;
      CTRL_lut_in        = 1'b0;
      CTRL_mem_to_reg    = 1'b0;
      CTRL_alu_src       = 1'b0;
      CTRL_alu_sc_in     = 1'b0;
      CTRL_read_mem      = 1'b0;
      CTRL_write_mem     = 1'b0;
      CTRL_alu_op        = 3'd0;
      if (r_state == S_RUN) begin
         case (opcode)
            4'h0: CTRL_reg_write_en = 1'b1;
            4'h1: begin CTRL_alu_op = 3'd1; CTRL_reg_write_en = 1'b1; end
            4'h2: begin CTRL_alu_op = 3'd2; CTRL_reg_write_en = 1'b1; end
            4'h3: begin CTRL_alu_op = 3'd3; CTRL_reg_write_en = 1'b1; end
            4'h4: begin CTRL_alu_op = 3'd4; CTRL_alu_sc_in = fcode; CTRL_reg_write_en = 1'b1; end
            4'h5: begin CTRL_alu_op = 3'd5; CTRL_alu_sc_in = fcode; CTRL_reg_write_en = 1'b1; end
            4'h6: begin CTRL_alu_src = 1'b1; CTRL_reg_write_en = 1'b1; end
            4'h7: CTRL_alu_op = 3'd1;
            4'h8: begin CTRL_read_mem = 1'b1; CTRL_mem_to_reg = 1'b1; CTRL_reg_write_en = 1'b1; end
            4'h9: CTRL_write_mem = 1'b1;
            4'hA: CTRL_branch_rel_nz = 1'b1;
            4'hB: CTRL_branch_rel_z = 1'b1;
            4'hC: CTRL_branch_abs = 1'b1;
            4'hD: begin CTRL_branch_abs = 1'b1; CTRL_lut_in = 1'b1; end
            4'hE: begin CTRL_reg_sel = 1'b1; CTRL_reg_write_en = 1'b1; end
            default: ;
         endcase
      end
   end

endmodule
